// File: rtl/popcount_share_arbiter_if.sv
// Requester/result bus of the shared popcount arbiter; res_parity exists only with POPCNT_PARITY_EN.
interface popcount_share_arbiter_if #(
  parameter int N    = 16,
  parameter int NREQ = 4
);
  localparam int CW = $clog2(N + 1);
  localparam int IW = $clog2(NREQ);

  logic [NREQ-1:0]   req;
  logic [NREQ*N-1:0] req_data;
  logic [NREQ-1:0]   grant;
  logic              res_valid;
  logic              res_ready;
  logic [IW-1:0]     res_id;
  logic [CW-1:0]     res_count;
`ifdef POPCNT_PARITY_EN
  logic              res_parity;

  modport master (
    output req, req_data, res_ready,
    input  grant, res_valid, res_id, res_count, res_parity
  );

  modport slave (
    input  req, req_data, res_ready,
    output grant, res_valid, res_id, res_count, res_parity
  );
`else
  modport master (
    output req, req_data, res_ready,
    input  grant, res_valid, res_id, res_count
  );

  modport slave (
    input  req, req_data, res_ready,
    output grant, res_valid, res_id, res_count
  );
`endif
endinterface

// File: rtl/popcount_share_arbiter.sv
// Round-robin shared popcount: grants one requester, counts its word, returns count+id; POPCNT_PARITY_EN adds res_parity.
// Grant to res_valid is 2 cycles; the result is held under res_ready backpressure and arbitration pauses until it drains.
module popcount_share_arbiter #(
  parameter int N    = 16,
  parameter int NREQ = 4
) (
  input logic                   clk,
  input logic                   rst,
  popcount_share_arbiter_if.slave bus
);
  localparam int CW = $clog2(N + 1);
  localparam int IW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t          state;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   lat_id;
  logic [N-1:0]    lat_word;
  logic            res_valid;
  logic [IW-1:0]   res_id;
  logic [CW-1:0]   res_count;
  logic [CW-1:0]   lat_count;
  logic [NREQ-1:0] grant;
  logic [N-1:0]    words [NREQ];
  logic            win_found;
  logic [IW-1:0]   win_id;
  logic [N-1:0]    win_word;

  function automatic logic [CW-1:0] popcount(input logic [N-1:0] w);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < N; i++) c = c + CW'(w[i]);
    return c;
  endfunction

  always_comb begin
    for (int k = 0; k < NREQ; k++) words[k] = bus.req_data[k*N +: N];
  end

  // First set request at or above ptr, wrapping past NREQ-1 back to 0.
  always_comb begin
    logic [IW-1:0] j;
    win_found = 1'b0;
    win_id    = '0;
    win_word  = '0;
    j         = '0;
    for (int i = 0; i < NREQ; i++) begin
      j = IW'((int'(ptr) + i) % NREQ);
      if (!win_found && bus.req[j]) begin
        win_found = 1'b1;
        win_id    = j;
        win_word  = words[j];
      end
    end
  end

  always_comb begin
    grant = '0;
    if (!rst && state == IDLE && win_found) grant[win_id] = 1'b1;
  end

  assign lat_count = popcount(lat_word);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      lat_id    <= '0;
      lat_word  <= '0;
      res_valid <= 1'b0;
      res_id    <= '0;
      res_count <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (win_found) begin
            lat_word <= win_word;
            lat_id   <= win_id;
            ptr      <= (win_id == IW'(NREQ - 1)) ? '0 : win_id + 1'b1;
            state    <= CALC;
          end
        end
        CALC: begin
          res_count <= lat_count;
          res_id    <= lat_id;
          res_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (bus.res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef POPCNT_PARITY_EN
  logic res_parity;

  always_ff @(posedge clk) begin
    if (rst) res_parity <= 1'b0;
    else if (state == CALC) res_parity <= lat_count[0];
  end

  assign bus.res_parity = res_parity;
`endif

  assign bus.grant     = grant;
  assign bus.res_valid = res_valid;
  assign bus.res_id    = res_id;
  assign bus.res_count = res_count;
endmodule

// File: tb/tb_popcount_share_arbiter.sv
// Bench for popcount_share_arbiter: directed scenarios plus random traffic against a job-queue reference model.
module tb_popcount_share_arbiter;
  localparam int N    = 16;
  localparam int NREQ = 4;

  typedef struct {
    int id;
    int cnt;
    int vis;
  } job_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  popcount_share_arbiter_if #(.N(N), .NREQ(NREQ)) bus ();
  popcount_share_arbiter #(.N(N), .NREQ(NREQ)) dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;

  // Reference model: at most one job in flight, its result visible from cycle 'vis' until taken.
  int   cyc      = 0;
  int   m_ptr    = 0;
  int   last_id  = 0;
  int   last_cnt = 0;
  job_t jobs[$];

  int gnt_idx[$];
  int gnt_cyc[$];
  int res_ids[$];
  int res_cnts[$];
  logic [NREQ-1:0] seen_grant;
  logic            seen_valid;
  int cont_exp[4] = '{0, 1, 8, 8};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic set_word(input int k, input logic [N-1:0] w);
    bus.req_data[k*N +: N] = w;
  endtask

  function automatic logic [N-1:0] rand_word();
    case ($urandom_range(0, 3))
      0:       return '0;
      1:       return '1;
      default: return N'($urandom);
    endcase
  endfunction

  task automatic clear_logs();
    gnt_idx.delete();
    gnt_cyc.delete();
    res_ids.delete();
    res_cnts.delete();
  endtask

  // One clock: check outputs at negedge against the model, then apply the edge to the model.
  task automatic run_cycle();
    int win;
    bit vis;
    int exp_id;
    int exp_cnt;
    logic [NREQ-1:0] eg;
    @(negedge clk);
    win = -1;
    if (!rst && jobs.size() == 0) begin
      for (int i = 0; i < NREQ; i++) begin
        int k;
        k = (m_ptr + i) % NREQ;
        if (win < 0 && bus.req[k]) win = k;
      end
    end
    eg = '0;
    if (win >= 0) eg[win] = 1'b1;
    vis     = (jobs.size() > 0) && (cyc >= jobs[0].vis);
    exp_id  = vis ? jobs[0].id  : last_id;
    exp_cnt = vis ? jobs[0].cnt : last_cnt;

    seen_grant = bus.grant;
    seen_valid = bus.res_valid;
    chk("grant", 32'(bus.grant), 32'(eg));
    chk("res_valid", 32'(bus.res_valid), 32'(vis));
    chk("res_id", 32'(bus.res_id), 32'(exp_id));
    chk("res_count", 32'(bus.res_count), 32'(exp_cnt));
`ifdef POPCNT_PARITY_EN
    chk("res_parity", 32'(bus.res_parity), 32'(exp_cnt % 2));
`endif

    for (int k = 0; k < NREQ; k++) begin
      if (bus.grant[k]) begin
        gnt_idx.push_back(k);
        gnt_cyc.push_back(cyc);
      end
    end
    if (!rst && bus.res_valid && bus.res_ready) begin
      res_ids.push_back(int'(bus.res_id));
      res_cnts.push_back(int'(bus.res_count));
    end

    if (rst) begin
      jobs.delete();
      m_ptr    = 0;
      last_id  = 0;
      last_cnt = 0;
    end else begin
      if (vis && bus.res_ready) begin
        last_id  = jobs[0].id;
        last_cnt = jobs[0].cnt;
        void'(jobs.pop_front());
      end
      if (win >= 0) begin
        job_t j;
        j.id  = win;
        j.cnt = $countones(bus.req_data[win*N +: N]);
        j.vis = cyc + 2;
        jobs.push_back(j);
        m_ptr = (win + 1) % NREQ;
      end
    end

    @(posedge clk);
    #1;
    cyc++;
    if (win >= 0) bus.req[win] = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    bus.req       = '0;
    bus.req_data  = '0;
    bus.res_ready = 1'b1;
    set_word(0, 16'h0000);
    set_word(1, 16'h0001);
    set_word(2, 16'h00FF);
    set_word(3, 16'hAAAA);
    bus.req = 4'hF;
    // DUT state is unknown until the first reset edge.
    @(posedge clk);
    #1;
    repeat (3) begin
      run_cycle();
      chk("rst_grant", 32'(seen_grant), 32'd0);
    end
    chk("rst_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_count", 32'(bus.res_count), 32'd0);
    chk("rst_id", 32'(bus.res_id), 32'd0);

    // Contention: all four requesters at once.
    rst = 1'b0;
    clear_logs();
    repeat (12) run_cycle();
    chk("cont_ngrant", 32'(gnt_idx.size()), 32'd4);
    chk("cont_nres", 32'(res_cnts.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < gnt_idx.size()) chk("cont_order", 32'(gnt_idx[i]), 32'(i));
      if (i > 0 && i < gnt_cyc.size()) chk("cont_gap", 32'(gnt_cyc[i] - gnt_cyc[i-1]), 32'd3);
      if (i < res_cnts.size()) begin
        chk("cont_count", 32'(res_cnts[i]), 32'(cont_exp[i]));
        chk("cont_id", 32'(res_ids[i]), 32'(i));
      end
    end

    // Single all-ones request.
    clear_logs();
    set_word(0, 16'hFFFF);
    bus.req = 4'b0001;
    repeat (4) run_cycle();
    chk("single_nres", 32'(res_cnts.size()), 32'd1);
    if (res_cnts.size() > 0) begin
      chk("single_count", 32'(res_cnts[0]), 32'd16);
      chk("single_id", 32'(res_ids[0]), 32'd0);
    end

    // Backpressure with another request pending.
    bus.res_ready = 1'b0;
    set_word(0, 16'h0F0F);
    bus.req = 4'b0001;
    run_cycle();
    set_word(1, 16'h0007);
    bus.req[1] = 1'b1;
    run_cycle();
    for (int i = 0; i < 5; i++) begin
      run_cycle();
      chk("bp_valid", 32'(seen_valid), 32'd1);
      chk("bp_grant", 32'(seen_grant), 32'd0);
      chk("bp_count", 32'(bus.res_count), 32'd8);
      chk("bp_id", 32'(bus.res_id), 32'd0);
    end
    bus.res_ready = 1'b1;
    run_cycle();
    run_cycle();
    chk("bp_next_grant", 32'(seen_grant), 32'b0010);
    repeat (3) run_cycle();

    // Wrap fairness: after requester 3 wins, 0 comes before 3.
    set_word(3, 16'h8001);
    bus.req = 4'b1000;
    run_cycle();
    chk("wrap_first", 32'(seen_grant), 32'b1000);
    clear_logs();
    set_word(0, 16'h0003);
    bus.req = 4'b1001;
    repeat (8) run_cycle();
    chk("wrap_ngrant", 32'(gnt_idx.size()), 32'd2);
    if (gnt_idx.size() > 1) begin
      chk("wrap_g0", 32'(gnt_idx[0]), 32'd0);
      chk("wrap_g1", 32'(gnt_idx[1]), 32'd3);
    end

    // Reset while a word is being counted.
    set_word(0, 16'hFFFF);
    bus.req = 4'b0001;
    run_cycle();
    rst = 1'b1;
    run_cycle();
    rst = 1'b0;
    clear_logs();
    set_word(2, 16'h0070);
    bus.req = 4'b0100;
    run_cycle();
    chk("midrst_valid", 32'(seen_valid), 32'd0);
    chk("midrst_grant", 32'(seen_grant), 32'b0100);
    repeat (3) run_cycle();
    chk("midrst_nres", 32'(res_cnts.size()), 32'd1);
    if (res_cnts.size() > 0) begin
      chk("midrst_id", 32'(res_ids[0]), 32'd2);
      chk("midrst_count", 32'(res_cnts[0]), 32'd3);
    end

    // Random traffic, occasional resets and backpressure.
    for (int n = 0; n < 3000; n++) begin
      rst           = ($urandom_range(0, 199) == 0);
      bus.res_ready = ($urandom_range(0, 9) < 7);
      for (int k = 0; k < NREQ; k++) begin
        if (!bus.req[k]) begin
          if ($urandom_range(0, 3) == 0) begin
            set_word(k, rand_word());
            bus.req[k] = 1'b1;
          end
        end else if ($urandom_range(0, 39) == 0) begin
          bus.req[k] = 1'b0;
        end
      end
      run_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
